rip_ma_stage: RTL and testbench
===============================

# rip_ma_stage

Memory-access (MA) stage of the rip pipeline: accepts one instruction per cycle from execute, performs load/store traffic on a request/grant/rvalid data-memory port, and drives the register file write port (`ma_rd_num`, `wen`, `wdata`). Loads stall upstream until data returns. Byte and halfword accesses are realigned and sign/zero-extended here, so the register file's same-cycle write-to-read bypass receives final architectural values.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles spent in REQ+WAIT before an access is aborted as a bus error (1..65535).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `ex_valid`  in  1  execute stage has an instruction.
- `ex_ready`  out  1  MA accepts it this cycle; equals `state==IDLE`.
- `ex_rd_num`  in  5  destination register.
- `ex_wb_en`  in  1  instruction writes `rd`.
- `ex_mem_op`  in  2  0 = none, 1 = load, 2 = store, 3 = none.
- `ex_funct3`  in  3  RISC-V width/sign field.
- `ex_alu_result`  in  32  ALU result or effective address.
- `ex_store_data`  in  32  rs2 value for stores.
- `dmem_req`, `dmem_we`  out  1  request, write enable (registered).
- `dmem_addr`  out  32  word-aligned address (`[1:0]`=0).
- `dmem_wstrb`  out  4  byte strobes.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data word.
- `ma_rd_num`  out  5  to regfile.
- `wen`  out  1  to regfile.
- `wdata`  out  32  to regfile.
- `ma_bus_err`  out  1  one-cycle pulse on timeout.
- `ma_misalign`  out  1  one-cycle pulse on misaligned access (macro-dependent).

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, accept (`ex_valid && ex_ready`):
  - none: next cycle `wen = ex_wb_en && rd!=0`, `wdata = ex_alu_result`.
  - load: latch rd/funct3/addr[1:0]; go REQ.
  - store: go REQ with `dmem_we=1`.
- REQ: `dmem_req` held with stable address/data until `dmem_gnt`.
  - On gnt, store -> IDLE, no `wen`.
  - On gnt, load -> WAIT.
- WAIT: on `dmem_rvalid`, go IDLE; next cycle `wen=1` (if rd!=0) with extracted data.
- Extraction by latched `addr[1:0]`:
  - LB(000)/LBU(100): byte lane `addr[1:0]`, sign/zero extend.
  - LH(001)/LHU(101): half lane `addr[1]`, sign/zero extend.
  - LW(010) and any other funct3: full word.
- Stores:
  - SB: `wstrb = 0001<<a`, byte replicated ×4.
  - SH: `wstrb = 0011<<a`, half replicated ×2.
  - SW/other: `wstrb = 1111`.
- `dmem_rvalid` and `dmem_gnt` are ignored outside WAIT/REQ respectively.
- Timeout:
  - 16-bit counter clears on entering REQ and counts every REQ/WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES`: `ma_bus_err` pulses, `dmem_req` drops, state -> IDLE, no `wen`.
  - A late `rvalid` after timeout is ignored.
- Simultaneous `dmem_gnt` and timeout: gnt wins.

## Timing
- Reset: state IDLE; all outputs 0 the cycle after `rst` is sampled high, including `dmem_req`.
- Reset mid-transaction aborts the access with no `wen`.
- Non-memory op accepted at cycle T: `wen` asserted at T+1. Back-to-back non-memory ops run at full rate.
- Load, gnt at G, rvalid at R (R > G): `dmem_req` is high T+1..G; `wen` at R+1. Zero-wait memory gives a 4-cycle load, with `ex_ready` low T+1..R.
- Store: `ex_ready` low T+1..G; returns high at G+1.
- `wen` is a single-cycle pulse per instruction.

## Configuration
- `RIP_MA_MISALIGN_TRAP_EN` defined:
  - Half access with `addr[0]=1`, or word access with `addr[1:0]!=0`, issues no dmem request.
  - `ma_misalign` pulses at T+1; no `wen`; state stays IDLE.
- Undefined:
  - `ma_misalign` tied 0.
  - Misaligned addresses are aligned down (half: `addr[0]` cleared; word: `addr[1:0]` cleared) and the access proceeds.

## Test plan
- ALU op rd=5, result 0x1234_5678 at T -> `wen=1`, `ma_rd_num=5`, `wdata=0x1234_5678` at T+1; rd=0 -> `wen=0`.
- LB addr 0x103, `dmem_rdata=0x80FF_0000`, gnt after 2 cycles, rvalid 1 cycle later -> `wdata=0xFFFF_FF80`, `ex_ready` low throughout. LBU same -> `0x0000_0080`.
- SH addr 0x202, data 0xAAAA_BEEF -> `dmem_addr=0x200`, `wstrb=1100`, `wdata=0xBEEF_BEEF`, `dmem_we=1`, `wen` never asserted.
- Load with `TIMEOUT_CYCLES=4`, no rvalid -> `ma_bus_err` pulse, `dmem_req` low, IDLE, no `wen`. Later stray rvalid ignored.
- `rst` asserted while in WAIT -> next cycle all outputs 0, `ex_ready=1`; rvalid arriving afterwards produces no `wen`.
- LW addr 0x101:
  - With the macro: `ma_misalign` pulse, no `dmem_req`.
  - Without it: `dmem_addr=0x100`, full-word result.

Source files
------------

// File: rtl/rip_ma_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : rip_ma_stage_if
// Purpose  : Request/grant/rvalid data-memory port of the rip MA stage.
// Revision : 1.0  initial release
// ============================================================================
interface rip_ma_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wstrb, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wstrb, wdata,
      output gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/rip_ma_stage.sv
`default_nettype none
// ============================================================================
// Module   : rip_ma_stage
// Purpose  : rip memory-access stage: load/store bus traffic, load realignment
//            and register-file write port. Optional RIP_MA_MISALIGN_TRAP_EN
//            turns misaligned half/word accesses into a trap pulse.
// Revision : 1.0  initial release
// ============================================================================
module rip_ma_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ex_valid_i,
   output logic           ex_ready_o,
   input  logic [4:0]     ex_rd_num_i,
   input  logic           ex_wb_en_i,
   input  logic [1:0]     ex_mem_op_i,
   input  logic [2:0]     ex_funct3_i,
   input  logic [31:0]    ex_alu_result_i,
   input  logic [31:0]    ex_store_data_i,
   rip_ma_stage_if.master dmem,
   output logic [4:0]     ma_rd_num_o,
   output logic           wen_o,
   output logic [31:0]    wdata_o,
   output logic           ma_bus_err_o,
   output logic           ma_misalign_o
);

   localparam logic [1:0]  c_S_IDLE   = 2'd0;
   localparam logic [1:0]  c_S_REQ    = 2'd1;
   localparam logic [1:0]  c_S_WAIT   = 2'd2;
   localparam logic [1:0]  c_SZ_B     = 2'd0;
   localparam logic [1:0]  c_SZ_H     = 2'd1;
   localparam logic [1:0]  c_SZ_W     = 2'd2;
   localparam logic [1:0]  c_OP_LOAD  = 2'd1;
   localparam logic [1:0]  c_OP_STORE = 2'd2;
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        is_store_q, is_store_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  rd_q, rd_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] sdata_q, sdata_d;
   logic [4:0]  rd_num_q, rd_num_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic        bus_err_q, bus_err_d;
   logic        misalign_q, misalign_d;

   logic        w_accept;
   logic        w_is_mem;
   logic [1:0]  w_size;
   logic [1:0]  w_lane;
   logic        w_trap;
   logic [3:0]  w_strb;
   logic [31:0] w_sdata;
   logic        w_timeout;
   logic [15:0] w_shifted;
   logic [31:0] w_load;

   assign w_accept  = ex_valid_i && (state_q == c_S_IDLE);
   assign w_is_mem  = (ex_mem_op_i == c_OP_LOAD) || (ex_mem_op_i == c_OP_STORE);
   assign w_timeout = (cnt_q == c_TMO_LAST);

   // Store widths use the plain funct3 code; loads ignore the unsigned bit.
   always_comb begin
      w_size = c_SZ_W;
      if (ex_mem_op_i == c_OP_STORE) begin
         if (ex_funct3_i == 3'b000)      w_size = c_SZ_B;
         else if (ex_funct3_i == 3'b001) w_size = c_SZ_H;
      end else begin
         if (ex_funct3_i[1:0] == 2'b00)      w_size = c_SZ_B;
         else if (ex_funct3_i[1:0] == 2'b01) w_size = c_SZ_H;
      end
   end

   always_comb begin
      w_lane  = 2'b00;
      w_strb  = 4'b1111;
      w_sdata = ex_store_data_i;
      case (w_size)
         c_SZ_B: begin
            w_lane  = ex_alu_result_i[1:0];
            w_strb  = 4'b0001 << w_lane;
            w_sdata = {4{ex_store_data_i[7:0]}};
         end
         c_SZ_H: begin
            w_lane  = {ex_alu_result_i[1], 1'b0};
            w_strb  = 4'b0011 << w_lane;
            w_sdata = {2{ex_store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef RIP_MA_MISALIGN_TRAP_EN
   assign w_trap = ((w_size == c_SZ_H) && ex_alu_result_i[0]) ||
                   ((w_size == c_SZ_W) && (ex_alu_result_i[1:0] != 2'b00));
`else
   assign w_trap = 1'b0;
`endif

   assign w_shifted = 16'(dmem.rdata >> {lane_q, 3'b000});

   always_comb begin
      case (size_q)
         c_SZ_B:  w_load = unsigned_q ? {24'd0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
         c_SZ_H:  w_load = unsigned_q ? {16'd0, w_shifted}
                                      : {{16{w_shifted[15]}}, w_shifted};
         default: w_load = dmem.rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (state_q == c_S_IDLE) ? 16'd0 : cnt_q + 16'd1;
      is_store_d = is_store_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      lane_d     = lane_q;
      rd_d       = rd_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wstrb_d    = wstrb_q;
      sdata_d    = sdata_q;
      rd_num_d   = rd_num_q;
      wen_d      = 1'b0;
      wdata_d    = wdata_q;
      bus_err_d  = 1'b0;
      misalign_d = 1'b0;

      case (state_q)
         c_S_IDLE: begin
            if (w_accept) begin
               if (w_is_mem && w_trap) begin
                  misalign_d = 1'b1;
               end else if (w_is_mem) begin
                  state_d    = c_S_REQ;
                  is_store_d = (ex_mem_op_i == c_OP_STORE);
                  size_d     = w_size;
                  unsigned_d = ex_funct3_i[2];
                  lane_d     = w_lane;
                  rd_d       = ex_rd_num_i;
                  req_d      = 1'b1;
                  we_d       = (ex_mem_op_i == c_OP_STORE);
                  addr_d     = {ex_alu_result_i[31:2], 2'b00};
                  wstrb_d    = (ex_mem_op_i == c_OP_STORE) ? w_strb : 4'b0000;
                  sdata_d    = (ex_mem_op_i == c_OP_STORE) ? w_sdata : 32'd0;
               end else begin
                  wen_d    = ex_wb_en_i && (ex_rd_num_i != 5'd0);
                  wdata_d  = ex_alu_result_i;
                  rd_num_d = ex_rd_num_i;
               end
            end
         end
         c_S_REQ: begin
            // A grant in the same cycle as the timeout still completes the access.
            if (dmem.gnt) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = is_store_q ? c_S_IDLE : c_S_WAIT;
            end else if (w_timeout) begin
               req_d     = 1'b0;
               we_d      = 1'b0;
               bus_err_d = 1'b1;
               state_d   = c_S_IDLE;
            end
         end
         c_S_WAIT: begin
            if (dmem.rvalid) begin
               state_d  = c_S_IDLE;
               wen_d    = (rd_q != 5'd0);
               wdata_d  = w_load;
               rd_num_d = rd_q;
            end else if (w_timeout) begin
               bus_err_d = 1'b1;
               state_d   = c_S_IDLE;
            end
         end
         default: state_d = c_S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= c_S_IDLE;
         cnt_q      <= '0;
         is_store_q <= 1'b0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         lane_q     <= '0;
         rd_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wstrb_q    <= '0;
         sdata_q    <= '0;
         rd_num_q   <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_store_q <= is_store_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         lane_q     <= lane_d;
         rd_q       <= rd_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wstrb_q    <= wstrb_d;
         sdata_q    <= sdata_d;
         rd_num_q   <= rd_num_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         bus_err_q  <= bus_err_d;
         misalign_q <= misalign_d;
      end
   end

   assign ex_ready_o    = (state_q == c_S_IDLE);
   assign dmem.req      = req_q;
   assign dmem.we       = we_q;
   assign dmem.addr     = addr_q;
   assign dmem.wstrb    = wstrb_q;
   assign dmem.wdata    = sdata_q;
   assign ma_rd_num_o   = rd_num_q;
   assign wen_o         = wen_q;
   assign wdata_o       = wdata_q;
   assign ma_bus_err_o  = bus_err_q;
   assign ma_misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_rip_ma_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rip_ma_stage
// Purpose  : Self-checking bench for rip_ma_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rip_ma_stage;
   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid_i, ex_ready_o, ex_wb_en_i;
   logic [4:0]  ex_rd_num_i, ma_rd_num_o;
   logic [1:0]  ex_mem_op_i;
   logic [2:0]  ex_funct3_i;
   logic [31:0] ex_alu_result_i, ex_store_data_i, wdata_o;
   logic        wen_o, ma_bus_err_o, ma_misalign_o;

   int n_checks = 0;
   int n_pass   = 0;

   rip_ma_stage_if dmem_if ();

   rip_ma_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid_i      (ex_valid_i),
      .ex_ready_o      (ex_ready_o),
      .ex_rd_num_i     (ex_rd_num_i),
      .ex_wb_en_i      (ex_wb_en_i),
      .ex_mem_op_i     (ex_mem_op_i),
      .ex_funct3_i     (ex_funct3_i),
      .ex_alu_result_i (ex_alu_result_i),
      .ex_store_data_i (ex_store_data_i),
      .dmem            (dmem_if),
      .ma_rd_num_o     (ma_rd_num_o),
      .wen_o           (wen_o),
      .wdata_o         (wdata_o),
      .ma_bus_err_o    (ma_bus_err_o),
      .ma_misalign_o   (ma_misalign_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // 0 = byte, 1 = half, 2 = word
   function automatic int size_of(input bit st, input logic [2:0] f3);
      if (st) return (f3 == 3'd0) ? 0 : (f3 == 3'd1) ? 1 : 2;
      return (f3 == 3'd0 || f3 == 3'd4) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2;
   endfunction

   function automatic int eff_lane(input int sz, input logic [31:0] a);
      if (sz == 0) return int'(a % 4);
      if (sz == 1) return int'((a % 4) / 2) * 2;
      return 0;
   endfunction

   function automatic bit traps(input int sz, input logic [31:0] a);
`ifdef RIP_MA_MISALIGN_TRAP_EN
      if (sz == 1) return (a % 2) != 0;
      if (sz == 2) return (a % 4) != 0;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
      int sz = size_of(1'b0, f3);
      int l  = eff_lane(sz, a);
      logic [31:0] v;
      if (sz == 0) begin
         v = (d >> (8 * l)) % 256;
         if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 1) begin
         v = (d >> (8 * l)) % 65536;
         if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(1'b1, f3);
      int l  = eff_lane(sz, a);
      if (sz == 0) return 4'(1 << l);
      if (sz == 1) return 4'(3 << l);
      return 4'd15;
   endfunction

   function automatic logic [31:0] exp_sdata(input logic [2:0] f3, input logic [31:0] d);
      int sz = size_of(1'b1, f3);
      if (sz == 0) return (d % 256) * 32'h0101_0101;
      if (sz == 1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] rd, input logic wb);
      ex_valid_i = 1'b1; ex_mem_op_i = op; ex_funct3_i = f3; ex_alu_result_i = alu;
      ex_store_data_i = sd; ex_rd_num_i = rd; ex_wb_en_i = wb;
   endtask

   task automatic idle_ex();
      ex_valid_i = 1'b0; ex_mem_op_i = 2'($urandom); ex_funct3_i = 3'($urandom);
      ex_alu_result_i = $urandom; ex_store_data_i = $urandom;
      ex_rd_num_i = 5'($urandom); ex_wb_en_i = 1'($urandom);
   endtask

   task automatic do_alu(input logic [1:0] op, input logic [4:0] rd, input logic wb,
                         input logic [31:0] res);
      logic ew = wb && (rd != 5'd0);
      drive_op(op, 3'($urandom), res, $urandom, rd, wb);
      @(negedge clk); idle_ex();
      n_checks++; if (wen_o !== ew) $display("FAIL alu_wen: got %b want %b", wen_o, ew); else n_pass++;
      if (ew) begin
         n_checks++; if (wdata_o !== res) $display("FAIL alu_wdata: got %h want %h", wdata_o, res); else n_pass++;
         n_checks++; if (ma_rd_num_o !== rd) $display("FAIL alu_rd: got %0d want %0d", ma_rd_num_o, rd); else n_pass++;
      end
      n_checks++; if (dmem_if.req !== 1'b0) $display("FAIL alu_req: got %b want 0", dmem_if.req); else n_pass++;
      @(negedge clk);
      n_checks++; if (wen_o !== 1'b0) $display("FAIL alu_pulse: got %b want 0", wen_o); else n_pass++;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd, input int g, input int r);
      logic [31:0] ev = exp_load(f3, a, d);
      drive_op(2'd1, f3, a, $urandom, rd, 1'($urandom));
      @(negedge clk); idle_ex();
      n_checks++; if (dmem_if.addr !== {a[31:2], 2'b00} || dmem_if.we !== 1'b0)
         $display("FAIL load_addr: got %h/%b want %h/0", dmem_if.addr, dmem_if.we, {a[31:2], 2'b00}); else n_pass++;
      for (int k = 1; k <= g; k++) begin
         dmem_if.gnt = (k == g); dmem_if.rvalid = 1'($urandom); dmem_if.rdata = $urandom;
         n_checks++; if ({dmem_if.req, ex_ready_o} !== 2'b10)
            $display("FAIL load_req: got req=%b rdy=%b want req=1 rdy=0", dmem_if.req, ex_ready_o); else n_pass++;
         @(negedge clk);
      end
      for (int k = 1; k <= r; k++) begin
         dmem_if.rvalid = (k == r); dmem_if.rdata = (k == r) ? d : $urandom; dmem_if.gnt = 1'($urandom);
         n_checks++; if ({dmem_if.req, ex_ready_o, wen_o} !== 3'b000)
            $display("FAIL load_wait: got req=%b rdy=%b wen=%b want 000", dmem_if.req, ex_ready_o, wen_o); else n_pass++;
         @(negedge clk);
      end
      dmem_if.rvalid = 1'b0; dmem_if.gnt = 1'b0;
      n_checks++; if (wen_o !== (rd != 5'd0) || ex_ready_o !== 1'b1)
         $display("FAIL load_wen: got wen=%b rdy=%b want wen=%b rdy=1", wen_o, ex_ready_o, rd != 5'd0); else n_pass++;
      if (rd != 5'd0) begin
         n_checks++; if (wdata_o !== ev) $display("FAIL load_data: got %h want %h", wdata_o, ev); else n_pass++;
         n_checks++; if (ma_rd_num_o !== rd) $display("FAIL load_rd: got %0d want %0d", ma_rd_num_o, rd); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (wen_o !== 1'b0) $display("FAIL load_pulse: got %b want 0", wen_o); else n_pass++;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int g);
      logic [3:0]  es = exp_strb(f3, a);
      logic [31:0] ed = exp_sdata(f3, d);
      drive_op(2'd2, f3, a, d, 5'($urandom_range(1, 31)), 1'b1);
      @(negedge clk); idle_ex();
      for (int k = 1; k <= g; k++) begin
         dmem_if.gnt = (k == g); dmem_if.rvalid = 1'($urandom);
         n_checks++; if ({dmem_if.req, dmem_if.we, ex_ready_o, wen_o} !== 4'b1100)
            $display("FAIL store_ctl: got req/we/rdy/wen=%b%b%b%b want 1100", dmem_if.req, dmem_if.we, ex_ready_o, wen_o); else n_pass++;
         n_checks++; if (dmem_if.addr !== {a[31:2], 2'b00}) $display("FAIL store_addr: got %h want %h", dmem_if.addr, {a[31:2], 2'b00}); else n_pass++;
         n_checks++; if (dmem_if.wstrb !== es) $display("FAIL store_strb: got %b want %b", dmem_if.wstrb, es); else n_pass++;
         n_checks++; if (dmem_if.wdata !== ed) $display("FAIL store_wdata: got %h want %h", dmem_if.wdata, ed); else n_pass++;
         @(negedge clk);
      end
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
      n_checks++; if ({dmem_if.req, ex_ready_o, wen_o} !== 3'b010)
         $display("FAIL store_done: got req/rdy/wen=%b%b%b want 010", dmem_if.req, ex_ready_o, wen_o); else n_pass++;
   endtask

   task automatic do_trap(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a);
      drive_op(op, f3, a, $urandom, 5'($urandom_range(1, 31)), 1'b1);
      @(negedge clk); idle_ex();
      n_checks++; if ({ma_misalign_o, dmem_if.req, wen_o, ex_ready_o} !== 4'b1001)
         $display("FAIL trap: got mis/req/wen/rdy=%b%b%b%b want 1001", ma_misalign_o, dmem_if.req, wen_o, ex_ready_o); else n_pass++;
      @(negedge clk);
      n_checks++; if (ma_misalign_o !== 1'b0) $display("FAIL trap_pulse: got %b want 0", ma_misalign_o); else n_pass++;
   endtask

   task automatic do_mem(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int g, input int r);
      if (traps(size_of(op == 2'd2, f3), a)) do_trap(op, f3, a);
      else if (op == 2'd1) do_load(f3, a, d, rd, g, r);
      else do_store(f3, a, d, g);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", ex_ready_o); else n_pass++;
      n_checks++; if ({dmem_if.req, dmem_if.we, wen_o, ma_bus_err_o, ma_misalign_o} !== 5'b0)
         $display("FAIL rst_ctl: got %b want 00000", {dmem_if.req, dmem_if.we, wen_o, ma_bus_err_o, ma_misalign_o}); else n_pass++;
      n_checks++; if ({dmem_if.addr, dmem_if.wstrb, dmem_if.wdata, wdata_o, ma_rd_num_o} !== 105'b0)
         $display("FAIL rst_data: got addr=%h strb=%b wd=%h wdata=%h rd=%0d want 0", dmem_if.addr, dmem_if.wstrb, dmem_if.wdata, wdata_o, ma_rd_num_o); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_alu();
      do_alu(2'd0, 5'd5, 1'b1, 32'h1234_5678);
      do_alu(2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF);
      do_alu(2'd3, 5'd17, 1'b1, 32'hCAFE_0001);
      do_alu(2'd0, 5'd9, 1'b0, 32'h0BAD_F00D);
   endtask

   task automatic test_subword_load();
      do_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 5'd10, 2, 1);
      do_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 5'd11, 2, 1);
      do_load(3'b001, 32'h0000_0042, 32'h9ABC_1234, 5'd12, 1, 1);
      do_load(3'b101, 32'h0000_0042, 32'h9ABC_1234, 5'd13, 1, 2);
      do_load(3'b010, 32'h0000_0080, 32'h7654_3210, 5'd0, 1, 1);
   endtask

   task automatic test_store();
      do_store(3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 2);
      do_store(3'b000, 32'h0000_0301, 32'h1234_56C3, 1);
      do_store(3'b010, 32'h0000_0400, 32'h0102_0304, 3);
   endtask

   task automatic test_misalign();
`ifdef RIP_MA_MISALIGN_TRAP_EN
      do_trap(2'd1, 3'b010, 32'h0000_0101);
      do_trap(2'd2, 3'b001, 32'h0000_0203);
`else
      n_checks++; if (ma_misalign_o !== 1'b0) $display("FAIL mis_tied: got %b want 0", ma_misalign_o); else n_pass++;
      do_load(3'b010, 32'h0000_0101, 32'h8765_4321, 5'd7, 1, 1);
      do_store(3'b001, 32'h0000_0203, 32'h0000_5AA5, 1);
`endif
   endtask

   task automatic test_back_to_back();
      logic [4:0]  prd = '0;
      logic        pwb = 1'b0;
      logic [31:0] pres = '0;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            n_checks++; if (ex_ready_o !== 1'b1 || wen_o !== (pwb && prd != 5'd0))
               $display("FAIL b2b_wen: got rdy=%b wen=%b want rdy=1 wen=%b", ex_ready_o, wen_o, pwb && prd != 5'd0); else n_pass++;
            if (pwb && prd != 5'd0) begin
               n_checks++; if (wdata_o !== pres || ma_rd_num_o !== prd)
                  $display("FAIL b2b_data: got %h/%0d want %h/%0d", wdata_o, ma_rd_num_o, pres, prd); else n_pass++;
            end
         end
         if (i < 6) begin
            prd = 5'($urandom); pwb = 1'($urandom); pres = $urandom;
            drive_op($urandom_range(0, 1) == 0 ? 2'd0 : 2'd3, 3'($urandom), pres, $urandom, prd, pwb);
         end else begin
            idle_ex();
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int kind = $urandom_range(0, 3);
         int g    = $urandom_range(1, 2);
         int r    = $urandom_range(1, 3 - g);
         if (kind == 1 || kind == 2)
            do_mem(2'(kind), 3'($urandom), $urandom, $urandom, 5'($urandom), g, r);
         else
            do_alu(2'(kind), 5'($urandom), 1'($urandom), $urandom);
      end
   endtask

   task automatic test_timeout();
      int n;
      drive_op(2'd1, 3'b010, 32'h0000_0040, $urandom, 5'd3, 1'b1);
      @(negedge clk); idle_ex();
      dmem_if.gnt = 1'b1;
      @(negedge clk);
      dmem_if.gnt = 1'b0;
      for (n = 2; n <= 10; n++) begin
         if (ma_bus_err_o === 1'b1) break;
         @(negedge clk);
      end
      n_checks++; if (n !== int'(TMO) + 1) $display("FAIL tmo_cycle: got %0d want %0d", n, TMO + 1); else n_pass++;
      n_checks++; if ({dmem_if.req, ex_ready_o, wen_o} !== 3'b010)
         $display("FAIL tmo_state: got req/rdy/wen=%b%b%b want 010", dmem_if.req, ex_ready_o, wen_o); else n_pass++;
      dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h5555_AAAA;
      @(negedge clk);
      dmem_if.rvalid = 1'b0;
      n_checks++; if ({ma_bus_err_o, wen_o} !== 2'b00) $display("FAIL tmo_stray: got err/wen=%b%b want 00", ma_bus_err_o, wen_o); else n_pass++;
      @(negedge clk);
      n_checks++; if (wen_o !== 1'b0) $display("FAIL tmo_nowen: got %b want 0", wen_o); else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive_op(2'd1, 3'b010, 32'h0000_345C, $urandom, 5'd9, 1'b1);
      @(negedge clk); idle_ex();
      dmem_if.gnt = 1'b1;
      @(negedge clk);
      dmem_if.gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if ({dmem_if.req, dmem_if.we, wen_o, ma_bus_err_o, ma_misalign_o, ex_ready_o} !== 6'b000001)
         $display("FAIL midrst_ctl: got %b want 000001", {dmem_if.req, dmem_if.we, wen_o, ma_bus_err_o, ma_misalign_o, ex_ready_o}); else n_pass++;
      n_checks++; if (dmem_if.addr !== 32'd0 || wdata_o !== 32'd0)
         $display("FAIL midrst_data: got addr=%h wdata=%h want 0", dmem_if.addr, wdata_o); else n_pass++;
      dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h1357_9BDF;
      @(negedge clk);
      dmem_if.rvalid = 1'b0;
      n_checks++; if (wen_o !== 1'b0) $display("FAIL midrst_stray: got %b want 0", wen_o); else n_pass++;
      @(negedge clk);
      n_checks++; if ({wen_o, dmem_if.req} !== 2'b00) $display("FAIL midrst_idle: got wen/req=%b%b want 00", wen_o, dmem_if.req); else n_pass++;
   endtask

   initial begin
      idle_ex();
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0;
      test_reset();
      test_alu();
      test_subword_load();
      test_store();
      test_misalign();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
`default_nettype wire
